// File: rtl/mem_req_scheduler.sv
// rtl/mem_req_scheduler.sv - memory request sequencer for one FlashAttention pass
//
// Purpose:
//   Walks the Q-tile / interleaved K,V / O-drain traffic of one attention pass
//   and presents it to the memory controller one request at a time over a
//   valid/ready channel. Loads are issued in strict order, gated by the target
//   SRAM's ready flag. Stores are drained whenever the O SRAM has a row, and
//   they take priority over loads.
//
// Ports:
//   clk         in   1        system clock
//   rst         in   1        asynchronous reset, active-high
//   start       in   1        begin pass (accepted only in IDLE or DONE)
//   q_sram_rdy  in   1        Q SRAM fill bank can accept a row
//   k_sram_rdy  in   1        K SRAM can accept a row
//   v_sram_rdy  in   1        V SRAM can accept a row
//   o_sram_vld  in   1        O SRAM drain bank holds a row to store
//   req_rdy     in   1        memory controller accepts the request
//   req_vld     out  1        request valid
//   req_cmd     out  2        01 load, 10 store, 00 when idle
//   req_sel     out  2        target: 0 Q, 1 K, 2 V, 3 O
//   req_addr    out  ADDR_W   byte address
//   busy        out  1        pass in progress
//   done        out  1        pass complete, held until next start
//   stall_cnt   out  32       cycles with req_vld & !req_rdy (MEM_SCHED_STATS_EN only)
//
// Configuration macro: MEM_SCHED_STATS_EN adds the stall_cnt output and counter.

module mem_req_scheduler #(
    parameter int              NUM_PES   = 4,
    parameter int              SEQ_LEN   = 16,
    parameter int              ADDR_W    = 32,
    parameter int              ROW_BYTES = 8,
    parameter logic [ADDR_W-1:0] Q_BASE  = 'h0000,
    parameter logic [ADDR_W-1:0] K_BASE  = 'h1000,
    parameter logic [ADDR_W-1:0] V_BASE  = 'h2000,
    parameter logic [ADDR_W-1:0] O_BASE  = 'h3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              q_sram_rdy,
    input  logic              k_sram_rdy,
    input  logic              v_sram_rdy,
    input  logic              o_sram_vld,
    input  logic              req_rdy,
    output logic              req_vld,
    output logic [1:0]        req_cmd,
    output logic [1:0]        req_sel,
    output logic [ADDR_W-1:0] req_addr,
`ifdef MEM_SCHED_STATS_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              busy,
    output logic              done
);

    localparam int NUM_TILES = SEQ_LEN / NUM_PES;
    localparam int CW        = $clog2(SEQ_LEN + 1);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;

    localparam logic [1:0] SEL_Q = 2'd0;
    localparam logic [1:0] SEL_K = 2'd1;
    localparam logic [1:0] SEL_V = 2'd2;
    localparam logic [1:0] SEL_O = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        LOAD_KV,
        WAIT_DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    // Load-side position: tile, Q row within tile, K/V row and K-or-V phase.
    logic [CW-1:0] tile_cnt;
    logic [CW-1:0] q_row;
    logic [CW-1:0] kv_idx;
    logic          kv_is_v;
    // Store-side position: stores handed to the output slot so far.
    logic [CW-1:0] st_cnt;

    logic              slot_free;
    logic              in_pass;
    logic              start_acc;
    logic              store_elig;
    logic              load_elig;
    logic              take_store;
    logic              take_load;
    logic              last_q;
    logic              last_kv;
    logic              last_tile;
    logic [1:0]        load_sel;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] q_addr;
    logic [ADDR_W-1:0] kv_addr;
    logic [ADDR_W-1:0] o_addr;

    assign q_addr  = Q_BASE + ADDR_W'((int'(tile_cnt) * NUM_PES + int'(q_row)) * ROW_BYTES);
    assign kv_addr = (kv_is_v ? V_BASE : K_BASE) + ADDR_W'(int'(kv_idx) * ROW_BYTES);
    assign o_addr  = O_BASE + ADDR_W'(int'(st_cnt) * ROW_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        start_acc  = 1'b0;
        load_elig  = 1'b0;
        load_sel   = SEL_Q;
        load_addr  = q_addr;

        // The output slot can take a new winner when empty or firing now.
        slot_free  = !req_vld || req_rdy;
        in_pass    = (state == LOAD_Q) || (state == LOAD_KV) || (state == WAIT_DRAIN);
        store_elig = in_pass && o_sram_vld && (st_cnt < CW'(SEQ_LEN));

        last_q    = (q_row == CW'(NUM_PES - 1));
        last_kv   = kv_is_v && (kv_idx == CW'(SEQ_LEN - 1));
        last_tile = (tile_cnt == CW'(NUM_TILES - 1));

        case (state)
            LOAD_Q: begin
                load_elig = q_sram_rdy;
                load_sel  = SEL_Q;
                load_addr = q_addr;
            end
            LOAD_KV: begin
                load_elig = kv_is_v ? v_sram_rdy : k_sram_rdy;
                load_sel  = kv_is_v ? SEL_V : SEL_K;
                load_addr = kv_addr;
            end
            default: ;
        endcase

        take_store = slot_free && store_elig;
        take_load  = slot_free && !store_elig && load_elig;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = LOAD_Q;
                end
            end
            LOAD_Q: begin
                if (take_load && last_q) begin
                    state_next = LOAD_KV;
                end
            end
            LOAD_KV: begin
                if (take_load && last_kv) begin
                    state_next = last_tile ? WAIT_DRAIN : LOAD_Q;
                end
            end
            WAIT_DRAIN: begin
                // Leave only once the final request has left the slot, so that
                // DONE never coexists with a pending request.
                if ((st_cnt == CW'(SEQ_LEN)) && slot_free) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy = in_pass;
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_cnt <= '0;
            q_row    <= '0;
            kv_idx   <= '0;
            kv_is_v  <= 1'b0;
            st_cnt   <= '0;
        end else if (start_acc) begin
            tile_cnt <= '0;
            q_row    <= '0;
            kv_idx   <= '0;
            kv_is_v  <= 1'b0;
            st_cnt   <= '0;
        end else begin
            if (take_load) begin
                if (state == LOAD_Q) begin
                    q_row <= last_q ? '0 : q_row + CW'(1);
                end else begin
                    kv_is_v <= !kv_is_v;
                    if (kv_is_v) begin
                        kv_idx <= (kv_idx == CW'(SEQ_LEN - 1)) ? '0 : kv_idx + CW'(1);
                    end
                    if (last_kv) begin
                        tile_cnt <= tile_cnt + CW'(1);
                    end
                end
            end
            if (take_store) begin
                st_cnt <= st_cnt + CW'(1);
            end
        end
    end

    // Output slot: holds the current request stable until it fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_vld  <= 1'b0;
            req_cmd  <= CMD_IDLE;
            req_sel  <= SEL_Q;
            req_addr <= '0;
        end else if (slot_free) begin
            if (take_store) begin
                req_vld  <= 1'b1;
                req_cmd  <= CMD_STORE;
                req_sel  <= SEL_O;
                req_addr <= o_addr;
            end else if (take_load) begin
                req_vld  <= 1'b1;
                req_cmd  <= CMD_LOAD;
                req_sel  <= load_sel;
                req_addr <= load_addr;
            end else begin
                req_vld  <= 1'b0;
                req_cmd  <= CMD_IDLE;
                req_sel  <= SEL_Q;
                req_addr <= '0;
            end
        end
    end

`ifdef MEM_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (req_vld && !req_rdy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
